// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice with registered carry, LSB first, WIDTH cycles per add.
// done pulses WIDTH cycles after accept; start is ignored outside IDLE (no queueing).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_s, bit_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        bit_s   = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        bit_c   = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = bit_c;
                acc_d  = {bit_s, acc_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                // Last slice: publish the accumulator including this bit's sum.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = acc_d;
                    cout_d  = bit_c;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
